// File: rtl/muldiv_iter.sv
// Iterative RV32M/RV64M multiply/divide unit: one bit per cycle over a fixed
// Width-cycle busy phase, with valid/ready handshakes on both sides.
module muldiv_iter #(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       funct3_i,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] res_o
);
    localparam int CW = $clog2(Width);
    localparam logic [CW-1:0] CntLoad = CW'(Width - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [2:0]       op_q;
    logic             neg_q;
    logic [Width-1:0] hi_q, lo_q, mcand_q;
    logic [Width-1:0] hi_d, lo_d;

    logic             a_sgn, b_sgn, sa, sb, b_zero, neg_acc;
    logic [Width-1:0] mag_a, mag_b;
    logic             accept, last;

    logic [Width:0]   sum, shifted;
    logic [Width-1:0] diff;

    // Sign correction of the final magnitudes and selection of the result half.
    function automatic logic [Width-1:0] final_result(input logic [2:0] op, input logic neg,
                                                      input logic [Width-1:0] hi,
                                                      input logic [Width-1:0] lo);
        logic [2*Width-1:0] prod;
        prod = neg ? -{hi, lo} : {hi, lo};
        if (!op[2]) return (op == 3'd0) ? prod[Width-1:0] : prod[2*Width-1:Width];
        if (op[1]) return neg ? -hi : hi;
        return neg ? -lo : lo;
    endfunction

    always_comb begin
        a_sgn  = (funct3_i != 3'd3) && (funct3_i != 3'd5) && (funct3_i != 3'd7);
        b_sgn  = a_sgn && (funct3_i != 3'd2);
        sa     = a_sgn & a_i[Width-1];
        sb     = b_sgn & b_i[Width-1];
        mag_a  = sa ? -a_i : a_i;
        mag_b  = sb ? -b_i : b_i;
        b_zero = (b_i == '0);
        // Division by zero must yield all ones regardless of the dividend sign.
        if (!funct3_i[2])    neg_acc = sa ^ sb;
        else if (funct3_i[1]) neg_acc = sa;
        else                  neg_acc = (sa ^ sb) & ~b_zero;
    end

    assign accept  = (state_q == S_IDLE) && valid_i && !flush_i;
    assign last    = (state_q == S_BUSY) && (cnt_q == '0) && !flush_i;
    assign ready_o = (state_q == S_IDLE);
    assign valid_o = (state_q == S_DONE);

    // hi/lo form a shift-right product accumulator for multiply and a
    // shift-left remainder/quotient pair for restoring division.
    always_comb begin
        sum     = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mcand_q : '0)};
        shifted = {hi_q, lo_q[Width-1]};
        diff    = shifted[Width-1:0] - mcand_q;
        if (op_q[2]) begin
            if (shifted >= {1'b0, mcand_q}) begin
                hi_d = diff;
                lo_d = {lo_q[Width-2:0], 1'b1};
            end else begin
                hi_d = shifted[Width-1:0];
                lo_d = {lo_q[Width-2:0], 1'b0};
            end
        end else begin
            hi_d = sum[Width:1];
            lo_d = {sum[0], lo_q[Width-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (valid_i && !flush_i) state_d = S_BUSY;
            S_BUSY: begin
                if (flush_i)            state_d = S_IDLE;
                else if (cnt_q == '0)   state_d = S_DONE;
            end
            S_DONE:  if (flush_i || ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            res_o   <= '0;
        end else begin
            state_q <= state_d;
            if (accept)
                cnt_q <= CntLoad;
            else if ((state_q == S_BUSY) && (cnt_q != '0))
                cnt_q <= cnt_q - 1'b1;
            if (last)
                res_o <= final_result(op_q, neg_q, hi_d, lo_d);
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            op_q    <= funct3_i;
            neg_q   <= neg_acc;
            mcand_q <= mag_b;
            lo_q    <= mag_a;
            hi_q    <= '0;
        end else if (state_q == S_BUSY) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter: randomized and directed operations checked
// against an arithmetic reference model, plus backpressure, flush and reset cases.
module tb_muldiv_iter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, flush_i, valid_i, ready_i;
    logic [2:0]   funct3_i;
    logic [W-1:0] a_i, b_i;
    logic         ready_o, valid_o;
    logic [W-1:0] res_o;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        logic [W-1:0] res;
        int           t;
    } exp_t;
    exp_t sb_q[$];

    logic         vprev = 1'b0;
    logic         held  = 1'b0;
    logic [W-1:0] held_res = '0;

    muldiv_iter #(.Width(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .funct3_i(funct3_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .res_o   (res_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    endtask

    function automatic logic [W-1:0] ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            3'd0, 3'd1: p = sa * sb;
            3'd2:       p = sa * ub;
            3'd3:       p = ua * ub;
            3'd4: begin
                if (b == '0) p = '1;
                else if (a == 32'h8000_0000 && b == '1) p = {32'd0, a};
                else p = sa / sb;
            end
            3'd5: begin
                if (b == '0) p = '1;
                else p = ua / ub;
            end
            3'd6: begin
                if (b == '0) p = {32'd0, a};
                else if (a == 32'h8000_0000 && b == '1) p = '0;
                else p = sa % sb;
            end
            default: begin
                if (b == '0) p = {32'd0, a};
                else p = ua % ub;
            end
        endcase
        return (op == 3'd1 || op == 3'd2 || op == 3'd3) ? p[63:32] : p[31:0];
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'd1;
            2:       return '1;
            3:       return 32'h8000_0000;
            4:       return W'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready_o && n < 200) begin
            step();
            n++;
        end
        if (!ready_o) check("ready_timeout", ready_o, 1);
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] want);
        wait_ready();
        if (!ready_o) return;
        funct3_i = op;
        a_i      = a;
        b_i      = b;
        valid_i  = 1'b1;
        sb_q.push_back('{res: want, t: cyc});
        step();
        valid_i  = 1'b0;
        funct3_i = 3'($urandom);
        a_i      = $urandom;
        b_i      = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        check("drain", sb_q.size(), 0);
    endtask

    // Monitor: latency on valid rise, result on handshake, stability while stalled.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            vprev = 1'b0;
            held  = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", valid_o, 1);
                check("hold_res", res_o, held_res);
            end
            if (valid_o && !vprev) begin
                if (sb_q.size() == 0) check("spurious_valid", valid_o, 0);
                else check("latency", cyc, sb_q[0].t + W + 1);
            end
            if (valid_o && ready_i && sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("result", res_o, e.res);
            end
            held     = valid_o && !ready_i;
            held_res = res_o;
            vprev    = valid_o;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad;
        logic [2:0]   op;
        logic [W-1:0] a, b;

        rst = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        funct3_i = '0; a_i = '0; b_i = '0;
        repeat (2) step();
        check("reset_ready", ready_o, 1);
        check("reset_valid", valid_o, 0);
        check("reset_res", res_o, 0);
        rst = 1'b0;
        step();

        issue(3'd0, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFCF);
        bad = 0;
        for (int i = 0; i < W + 1; i++) begin
            if (ready_o) bad++;
            step();
        end
        check("busy_ready_low", bad, 0);

        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        issue(3'd5, 32'd7, 32'd2, 32'd3);
        issue(3'd7, 32'd7, 32'd2, 32'd1);
        issue(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);
        issue(3'd7, 32'd5, 32'd0, 32'd5);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        for (int i = 0; i < 48; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            issue(op, a, b, ref_model(op, a, b));
        end
        drain();

        // Backpressure with ignored requests while the result is stalled.
        ready_i = 1'b0;
        issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, ref_model(3'd1, 32'h1234_5678, 32'h9ABC_DEF0));
        bad = 0;
        while (!valid_o && bad < 100) begin
            step();
            bad++;
        end
        check("bp_valid_seen", valid_o, 1);
        for (int i = 0; i < 5; i++) begin
            valid_i  = 1'b1;
            funct3_i = 3'($urandom);
            a_i      = $urandom;
            b_i      = $urandom;
            check("bp_ready_low", ready_o, 0);
            step();
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        step();
        check("bp_ready_back", ready_o, 1);
        check("bp_valid_gone", valid_o, 0);
        issue(3'd5, 32'd100, 32'd7, 32'd14);
        drain();

        // Flush in the tenth busy cycle.
        wait_ready();
        funct3_i = 3'd4; a_i = 32'd1000; b_i = 32'd3; valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        repeat (9) step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("flush_busy_idle", ready_o, 1);
        check("flush_busy_valid", valid_o, 0);
        repeat (40) step();

        // Flush together with a request in Idle.
        flush_i = 1'b1; valid_i = 1'b1; funct3_i = 3'd0; a_i = 32'd3; b_i = 32'd3;
        step();
        flush_i = 1'b0; valid_i = 1'b0;
        check("flush_idle_noaccept", ready_o, 1);
        repeat (40) step();
        issue(3'd5, 32'd7, 32'd2, 32'd3);
        drain();

        // Asynchronous reset in the middle of an operation.
        wait_ready();
        funct3_i = 3'd3; a_i = 32'hDEAD_BEEF; b_i = 32'hCAFE_F00D; valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        repeat (5) step();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", valid_o, 0);
        check("async_rst_ready", ready_o, 1);
        check("async_rst_res", res_o, 0);
        step();
        rst = 1'b0;
        repeat (40) step();
        issue(3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1);
        drain();
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Parametrised, iterative multiply/divide unit implementing the RV32M/RV64M integer ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Sits beside the single-cycle ALU in the execute stage.
- The core issues an operation through a valid/ready handshake. The unit computes over a fixed number of cycles, one bit per cycle, and returns the result through a second valid/ready handshake.
- The core can abort an in-flight operation with flush_i.

Parameters:
- Width, default Xlen (32), operand and result width; any even value ≥ 8 is legal.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- flush_i  in  1  synchronous abort of any in-flight or completed operation
- valid_i  in  1  operation request
- ready_o  out  1  unit can accept a request
- funct3_i  in  3  op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- a_i  in  Width  operand rs1
- b_i  in  Width  operand rs2
- valid_o  out  1  result valid
- ready_i  in  1  consumer accepts result
- res_o  out  Width  result

Behaviour:
- States and outputs:
  - Idle: ready_o=1, valid_o=0.
  - Busy: ready_o=0, valid_o=0.
  - Done: ready_o=0, valid_o=1.
  - ready_o and valid_o decode directly from state.
- Reset (async, rst_i=1): state=Idle, counter=0, res_o=0, valid_o=0, ready_o=1. Reset mid-operation discards all work; no valid_o follows.
- Accept (Idle, valid_i=1, flush_i=0):
  - Register funct3_i, a_i and b_i. Later changes on those inputs are ignored.
  - Record result sign and operand magnitudes.
  - Load counter=Width−1 and go to Busy.
- Busy: one iteration per cycle.
  - Multiply: shift-add, unsigned magnitudes, 2·Width accumulator.
  - Divide: restoring, unsigned magnitudes, one quotient bit per cycle.
  - When counter=0, apply sign correction, register res_o and go to Done.
- Latency: if accept occurs in cycle T, valid_o is first high in cycle T+Width+1, independent of op and operand values. There are no early-outs.
- Signedness:
  - MUL and MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: both operands unsigned.
  - DIV and REM: both operands signed.
  - Product sign = sign(a) XOR sign(b), for the signed operands only.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
  - Most-negative magnitude is handled as unsigned 2^(Width−1), with no overflow.
- Results:
  - MUL: low Width bits of the product.
  - MULH, MULHSU, MULHU: high Width bits of the 2·Width signed product.
- Special cases, at the same fixed latency:
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return a_i.
  - Signed overflow (a = −2^(Width−1), b = −1): DIV returns a_i; REM returns 0.
- Done:
  - res_o and valid_o are held stable until ready_i=1.
  - On the handshake cycle, go to Idle. ready_o rises the following cycle, so there is one bubble and no same-cycle re-accept.
- flush_i:
  - In Busy or Done: next state Idle, valid_o=0; the result is lost.
  - In Idle: no request is accepted that cycle, even if valid_i=1.
  - flush_i takes priority over accept and over the result handshake.
- valid_i while not Idle is ignored; no request is queued.
- res_o holds its last value after leaving Done. Consumers rely on it only while valid_o=1.

Test Plan:
- Width=32, MUL a=7, b=0xFFFFFFF9 (−7) accepted in cycle T -> valid_o first high in cycle T+33 with res_o=0xFFFFFFCF (−49); ready_o=0 for cycles T+1..T+33.
- High products:
  - MULH 0x80000000×0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- Signed and unsigned division:
  - DIV 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFD.
  - REM same operands -> 0xFFFFFFFF.
  - DIVU 7/2 -> 3.
  - REMU 7/2 -> 1.
- Corner cases, each with latency still exactly 33 cycles:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM same operands -> 0.
- Backpressure: hold ready_i=0 for 5 cycles after valid_o rises, with valid_i=1 and changing operands -> res_o and valid_o stay stable and ready_o=0. When ready_i=1, the handshake completes, ready_o returns to 1 one cycle later, and the next request is accepted.
- Aborts:
  - flush_i pulsed in Busy cycle 10 -> Idle next cycle, valid_o never asserts.
  - flush_i=1 with valid_i=1 in Idle -> no accept.
  - rst_i asserted asynchronously mid-Busy -> outputs go immediately to reset values (valid_o=0, ready_o=1, res_o=0).
